// File: rtl/capp_pkg.sv
// capp_pkg: opcodes, FSM states and default timing
// for the CAPP command sequencer.
package capp_pkg;

   localparam logic [2:0] OP_NOP          = 3'd0;
   localparam logic [2:0] OP_SET_ALL      = 3'd1;
   localparam logic [2:0] OP_SEARCH       = 3'd2;
   localparam logic [2:0] OP_SELECT_FIRST = 3'd3;
   localparam logic [2:0] OP_WRITE        = 3'd4;
   localparam logic [2:0] OP_READ         = 3'd5;
   localparam logic [2:0] OP_SEARCH_WRITE = 3'd6;
   localparam logic [2:0] OP_READ_NEXT    = 3'd7;

   localparam int CAPP_SEARCH_LAT = 2;

   typedef enum logic [2:0] {
      IDLE,
      SRCH,
      SWAIT,
      SEL,
      WR,
      RD,
      RSP
   } state_t;

endpackage

// File: rtl/capp_sequencer_if.sv
// capp_sequencer_if: host-side command and response
// handshakes of the CAPP sequencer.
interface capp_sequencer_if #(
   parameter int num_bits = 32
) ();

   logic                cmd_valid;
   logic                cmd_ready;
   logic [2:0]          cmd_op;
   logic [num_bits-1:0] cmd_comparand;
   logic [num_bits-1:0] cmd_mask;
   logic                rsp_valid;
   logic                rsp_ready;
   logic                rsp_any;
   logic [num_bits-1:0] rsp_data;

   modport master (
      output cmd_valid,
      output cmd_op,
      output cmd_comparand,
      output cmd_mask,
      output rsp_ready,
      input  cmd_ready,
      input  rsp_valid,
      input  rsp_any,
      input  rsp_data
   );

   modport slave (
      input  cmd_valid,
      input  cmd_op,
      input  cmd_comparand,
      input  cmd_mask,
      input  rsp_ready,
      output cmd_ready,
      output rsp_valid,
      output rsp_any,
      output rsp_data
   );

endinterface

// File: rtl/capp_write_encoder.sv
// capp_write_encoder: maps data/mask to the array's
// two-wire-per-bit write encoding (00 = keep bit).
module capp_write_encoder
   import capp_pkg::*;
#(
   parameter int num_bits = 32
) (
   input  logic [num_bits-1:0]   data,
   input  logic [num_bits-1:0]   mask,
   output logic [2*num_bits-1:0] write_lines
);

   always_comb begin
      write_lines = '0;
      for (int i = 0; i < num_bits; i++) begin
         if (mask[i]) begin
            write_lines[2*i+1] = data[i];
            write_lines[2*i]   = ~data[i];
         end
      end
   end

endmodule

// File: rtl/capp_sequencer.sv
// capp_sequencer: expands one associative command at a
// time into timed strobes on the CAPP array.
module capp_sequencer
   import capp_pkg::*;
#(
   parameter int num_bits   = 32,
   parameter int num_cells  = 100,
   parameter int SEARCH_LAT = CAPP_SEARCH_LAT
) (
   input  logic                  CLK,
   input  logic                  RST,
   capp_sequencer_if.slave       bus,
   output logic                  busy,
   output logic [num_bits-1:0]   comparand,
   output logic [num_bits-1:0]   mask,
   output logic                  perform_search,
   output logic                  set,
   output logic                  select_first,
   output logic [2*num_bits-1:0] write_lines,
   input  logic [num_cells-1:0]  tag_wires,
   input  logic [num_bits-1:0]   read_lines
);

   localparam int CW = $clog2(SEARCH_LAT + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(SEARCH_LAT - 1);

   state_t state_q, state_d;
   logic [2:0] op_q, op_d;
   logic [num_bits-1:0] comparand_q, comparand_d;
   logic [num_bits-1:0] mask_q, mask_d;
   logic [num_bits-1:0] rsp_data_q, rsp_data_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic rsp_any_q, rsp_any_d;
   logic ps_q, ps_d;
   logic set_q, set_d;
   logic sel_q, sel_d;
   logic [2*num_bits-1:0] wl_q, wl_d;
   logic ready_en_q;

   logic accept;
   logic any_tag;
   logic rsp_valid;
   logic [2:0] op_cur;
   logic [num_bits-1:0] data_cur;
   logic [num_bits-1:0] mask_cur;
   logic [2*num_bits-1:0] wl_enc;
   state_t srch_done;

   assign any_tag   = |tag_wires;
   assign rsp_valid = (state_q == RSP);

   assign bus.cmd_ready = ready_en_q
                        & (state_q == IDLE)
                        & ~rsp_valid;
   assign accept = bus.cmd_valid & bus.cmd_ready;

   // Strobes are registered on the accept edge, so
   // they must see the incoming fields, not the regs.
   assign op_cur   = accept ? bus.cmd_op : op_q;
   assign data_cur = accept ? bus.cmd_comparand
                            : comparand_q;
   assign mask_cur = accept ? bus.cmd_mask : mask_q;

   capp_write_encoder #(
      .num_bits (num_bits)
   ) u_enc (
      .data        (data_cur),
      .mask        (mask_cur),
      .write_lines (wl_enc)
   );

   assign srch_done =
      ((op_q == OP_SEARCH_WRITE) && any_tag) ? WR : RSP;

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      comparand_d = comparand_q;
      mask_d      = mask_q;
      rsp_data_d  = rsp_data_q;
      rsp_any_d   = rsp_any_q;
      cnt_d       = cnt_q;
      ps_d        = 1'b0;
      set_d       = 1'b0;
      sel_d       = 1'b0;
      wl_d        = '0;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               op_d        = bus.cmd_op;
               comparand_d = bus.cmd_comparand;
               mask_d      = bus.cmd_mask;
               rsp_data_d  = '0;
               rsp_any_d   = 1'b0;
               cnt_d       = CNT_LOAD;
               unique case (bus.cmd_op)
                  OP_NOP:          state_d = RSP;
                  OP_SET_ALL:      state_d = SEL;
                  OP_SELECT_FIRST: state_d = SEL;
                  OP_READ_NEXT:    state_d = SEL;
                  OP_SEARCH:       state_d = SRCH;
                  OP_SEARCH_WRITE: state_d = SRCH;
                  OP_WRITE:        state_d = WR;
                  OP_READ:         state_d = RD;
                  default:         state_d = RSP;
               endcase
            end
         end
         SRCH: begin
            if (cnt_q == '0) state_d = srch_done;
            else             state_d = SWAIT;
         end
         SWAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) state_d = srch_done;
         end
         SEL: begin
            if (op_q == OP_READ_NEXT) state_d = RD;
            else                      state_d = RSP;
         end
         WR: state_d = RSP;
         RD: begin
            rsp_data_d = read_lines;
            state_d    = RSP;
         end
         RSP: begin
            if (bus.rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      ps_d  = (state_d == SRCH);
      set_d = (state_d == SEL)
            && (op_cur == OP_SET_ALL);
      sel_d = (state_d == SEL)
            && (op_cur != OP_SET_ALL);
      if (state_d == WR) wl_d = wl_enc;
      if ((state_d == RSP) && (state_q != RSP))
         rsp_any_d = any_tag;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= IDLE;
         op_q        <= OP_NOP;
         comparand_q <= '0;
         mask_q      <= '0;
         rsp_data_q  <= '0;
         rsp_any_q   <= 1'b0;
         cnt_q       <= '0;
         ps_q        <= 1'b0;
         set_q       <= 1'b0;
         sel_q       <= 1'b0;
         wl_q        <= '0;
         ready_en_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         comparand_q <= comparand_d;
         mask_q      <= mask_d;
         rsp_data_q  <= rsp_data_d;
         rsp_any_q   <= rsp_any_d;
         cnt_q       <= cnt_d;
         ps_q        <= ps_d;
         set_q       <= set_d;
         sel_q       <= sel_d;
         wl_q        <= wl_d;
         ready_en_q  <= 1'b1;
      end
   end

   assign busy           = (state_q != IDLE);
   assign comparand      = comparand_q;
   assign mask           = mask_q;
   assign perform_search = ps_q;
   assign set            = set_q;
   assign select_first   = sel_q;
   assign write_lines    = wl_q;
   assign bus.rsp_valid  = rsp_valid;
   assign bus.rsp_any    = rsp_any_q;
   assign bus.rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_capp_sequencer.sv
// tb_capp_sequencer: scoreboard bench with a behavioural
// CAPP array model driven by the sequencer strobes.
module tb_capp_sequencer;
   import capp_pkg::*;

   localparam int NB = 32;
   localparam int NC = 100;
   localparam int SL = 2;

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   capp_sequencer_if #(.num_bits(NB)) bus ();

   logic            busy;
   logic [NB-1:0]   comparand, mask, read_lines;
   logic            perform_search, set, select_first;
   logic [2*NB-1:0] write_lines;
   logic [NC-1:0]   tag_wires;

   capp_sequencer #(
      .num_bits   (NB),
      .num_cells  (NC),
      .SEARCH_LAT (SL)
   ) dut (
      .CLK            (CLK),
      .RST            (RST),
      .bus            (bus),
      .busy           (busy),
      .comparand      (comparand),
      .mask           (mask),
      .perform_search (perform_search),
      .set            (set),
      .select_first   (select_first),
      .write_lines    (write_lines),
      .tag_wires      (tag_wires),
      .read_lines     (read_lines)
   );

   // Array model: tags/cells update on the edge that
   // samples a strobe; read_lines is the wired-OR.
   logic [NB-1:0] cells [NC];
   logic [NC-1:0] tags;
   logic          pre_en = 1'b0;
   logic [NB-1:0] pre_cells [NC];
   logic [NC-1:0] pre_tags = '0;

   function automatic logic [NC-1:0] first_only(
      input logic [NC-1:0] t);
      logic [NC-1:0] r;
      bit found;
      r = '0;
      found = 0;
      for (int i = 0; i < NC; i++)
         if (t[i] && !found) begin
            r[i] = 1'b1;
            found = 1;
         end
      return r;
   endfunction

   always @(posedge CLK) begin
      if (pre_en) begin
         for (int i = 0; i < NC; i++) cells[i] <= pre_cells[i];
         tags <= pre_tags;
      end else if (set) begin
         tags <= '1;
      end else if (select_first) begin
         tags <= first_only(tags);
      end else if (perform_search) begin
         for (int i = 0; i < NC; i++)
            tags[i] <= tags[i]
               & (((cells[i] ^ comparand) & mask) == '0);
      end else if (write_lines != '0) begin
         for (int i = 0; i < NC; i++)
            if (tags[i])
               for (int j = 0; j < NB; j++)
                  if (write_lines[2*j+1]) cells[i][j] <= 1'b1;
                  else if (write_lines[2*j]) cells[i][j] <= 1'b0;
      end
   end

   always_comb begin
      read_lines = '0;
      for (int i = 0; i < NC; i++)
         if (tags[i]) read_lines = read_lines | cells[i];
   end
   assign tag_wires = tags;

   int cyc = 0, acc_cyc = 0, hs_cyc = 0;
   int ps_cnt = 0, ps_at = 0, set_cnt = 0, set_at = 0;
   int sel_cnt = 0, sel_at = 0, wl_cnt = 0, wl_at = 0;
   logic [2*NB-1:0] wl_val = '0;

   always @(posedge CLK) begin
      cyc = cyc + 1;
      if (bus.cmd_valid && bus.cmd_ready) begin
         acc_cyc = cyc;
         ps_cnt = 0; set_cnt = 0; sel_cnt = 0; wl_cnt = 0;
         ps_at = 0; set_at = 0; sel_at = 0; wl_at = 0;
         wl_val = '0;
      end
      if (bus.rsp_valid && bus.rsp_ready) hs_cyc = cyc;
   end

   always @(negedge CLK) begin
      if (perform_search) begin
         ps_cnt++; ps_at = cyc - acc_cyc + 1;
      end
      if (set) begin
         set_cnt++; set_at = cyc - acc_cyc + 1;
      end
      if (select_first) begin
         sel_cnt++; sel_at = cyc - acc_cyc + 1;
      end
      if (write_lines != '0) begin
         wl_cnt++; wl_at = cyc - acc_cyc + 1;
         wl_val = write_lines;
      end
   end

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic          any;
      logic [NB-1:0] data;
      int            lat;
   } exp_t;
   exp_t sb[$];

   task automatic preload(input logic [NC-1:0] t);
      @(negedge CLK);
      pre_en = 1'b1;
      pre_tags = t;
      @(negedge CLK);
      pre_en = 1'b0;
   endtask

   task automatic clear_cells();
      for (int i = 0; i < NC; i++) pre_cells[i] = '0;
   endtask

   task automatic issue(input logic [2:0] op,
                        input logic [NB-1:0] c,
                        input logic [NB-1:0] m,
                        input bit push,
                        input logic eany,
                        input logic [NB-1:0] edata,
                        input int elat);
      exp_t e;
      int n;
      e.any = eany; e.data = edata; e.lat = elat;
      if (push) sb.push_back(e);
      @(negedge CLK);
      bus.cmd_valid = 1'b1;
      bus.cmd_op = op;
      bus.cmd_comparand = c;
      bus.cmd_mask = m;
      n = 0;
      while (!bus.cmd_ready && n < 20) begin
         @(negedge CLK);
         n++;
      end
      checks++;
      if (bus.cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL accept_timeout: cmd_ready=%b required 1",
                  bus.cmd_ready);
      end
      @(posedge CLK);
      #1;
      bus.cmd_valid = 1'b0;
      bus.cmd_op = ~op;
      bus.cmd_comparand = ~c;
      bus.cmd_mask = ~m;
   endtask

   task automatic get_rsp(input string name);
      exp_t e;
      int n, lat;
      n = 0;
      @(negedge CLK);
      while (!bus.rsp_valid && n < 50) begin
         @(negedge CLK);
         n++;
      end
      lat = cyc - acc_cyc + 1;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s_sb: scoreboard empty, required 1 entry",
                  name);
      end else begin
         e = sb.pop_front();
         if (bus.rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: rsp_valid=%b required 1",
                     name, bus.rsp_valid);
         end else begin
            checks++;
            if (lat != e.lat) begin
               errors++;
               $display("FAIL %s_lat: got T%0d required T%0d",
                        name, lat, e.lat);
            end
            checks++;
            if (bus.rsp_any !== e.any) begin
               errors++;
               $display("FAIL %s_any: got %b required %b",
                        name, bus.rsp_any, e.any);
            end
            checks++;
            if (bus.rsp_data !== e.data) begin
               errors++;
               $display("FAIL %s_data: got %h required %h",
                        name, bus.rsp_data, e.data);
            end
         end
      end
      if (bus.rsp_ready) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_op = OP_NOP;
      bus.cmd_comparand = '0;
      bus.cmd_mask = '0;
      bus.rsp_ready = 1'b1;
      clear_cells();
      preload('0);
      @(negedge CLK);
      checks++;
      if ({bus.cmd_ready, bus.rsp_valid, busy,
           perform_search, set, select_first} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctl: got %b required 000000",
                  {bus.cmd_ready, bus.rsp_valid, busy,
                   perform_search, set, select_first});
      end
      checks++;
      if ({write_lines, comparand, mask, bus.rsp_data,
           bus.rsp_any} !== '0) begin
         errors++;
         $display("FAIL reset_data: wl=%h cmp=%h msk=%h d=%h required 0",
                  write_lines, comparand, mask, bus.rsp_data);
      end
      RST = 1'b0;
      #1;
      checks++;
      if (bus.cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: cmd_ready=%b required 0",
                  bus.cmd_ready);
      end
      @(negedge CLK);
      checks++;
      if (bus.cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: cmd_ready=%b required 1",
                  bus.cmd_ready);
      end
   endtask

   task automatic test_nop();
      issue(OP_NOP, '0, '0, 1, 1'b0, '0, 1);
      get_rsp("nop");
   endtask

   task automatic test_search();
      clear_cells();
      pre_cells[7] = 32'h0000_12A5;
      preload('0);
      issue(OP_SET_ALL, '0, '0, 1, 1'b0, '0, 2);
      get_rsp("set_all");
      checks++;
      if (set_cnt != 1 || set_at != 1) begin
         errors++;
         $display("FAIL set_strobe: count=%0d at T%0d required 1 at T1",
                  set_cnt, set_at);
      end
      issue(OP_SEARCH, 32'h0000_00A5, 32'h0000_00FF,
            1, 1'b1, '0, 1 + SL);
      get_rsp("search");
      checks++;
      if (ps_cnt != 1 || ps_at != 1) begin
         errors++;
         $display("FAIL search_strobe: count=%0d at T%0d required 1 at T1",
                  ps_cnt, ps_at);
      end
      checks++;
      if ({comparand, mask} !== {32'h0000_00A5, 32'h0000_00FF}) begin
         errors++;
         $display("FAIL search_hold: cmp=%h msk=%h required 000000a5 000000ff",
                  comparand, mask);
      end
   endtask

   task automatic test_write();
      issue(OP_WRITE, 32'h0000_000F, 32'h0000_0003,
            1, 1'b1, '0, 2);
      get_rsp("write");
      checks++;
      if (wl_cnt != 1 || wl_at != 1) begin
         errors++;
         $display("FAIL write_strobe: count=%0d at T%0d required 1 at T1",
                  wl_cnt, wl_at);
      end
      checks++;
      if (wl_val !== 64'h0000_0000_0000_000A) begin
         errors++;
         $display("FAIL write_lines: got %h required 000000000000000a",
                  wl_val);
      end
   endtask

   task automatic test_search_write_nomatch();
      clear_cells();
      preload('1);
      issue(OP_SEARCH_WRITE, 32'hDEAD_BEEF, 32'hFFFF_FFFF,
            1, 1'b0, '0, 1 + SL);
      get_rsp("sw_nomatch");
      checks++;
      if (wl_cnt != 0 || ps_cnt != 1) begin
         errors++;
         $display("FAIL sw_nomatch_strobes: wl=%0d ps=%0d required 0 1",
                  wl_cnt, ps_cnt);
      end
   endtask

   task automatic test_search_write_match();
      clear_cells();
      pre_cells[5] = 32'h0000_0001;
      preload('1);
      issue(OP_SEARCH_WRITE, 32'h0000_0001, 32'h0000_0001,
            1, 1'b1, '0, 2 + SL);
      get_rsp("sw_match");
      checks++;
      if (wl_cnt != 1 || wl_at != 1 + SL || wl_val !== 64'h2) begin
         errors++;
         $display("FAIL sw_match_write: count=%0d at T%0d val=%h required 1 at T%0d val 2",
                  wl_cnt, wl_at, wl_val, 1 + SL);
      end
   endtask

   task automatic test_read_next();
      logic [NC-1:0] t;
      clear_cells();
      pre_cells[3] = 32'h0000_0055;
      pre_cells[9] = 32'h0000_00AA;
      t = '0;
      t[3] = 1'b1;
      t[9] = 1'b1;
      preload(t);
      issue(OP_READ_NEXT, '0, '0, 1, 1'b1, 32'h0000_0055, 3);
      get_rsp("read_next");
      checks++;
      if (sel_cnt != 1 || sel_at != 1) begin
         errors++;
         $display("FAIL sel_strobe: count=%0d at T%0d required 1 at T1",
                  sel_cnt, sel_at);
      end
   endtask

   task automatic test_backpressure();
      bus.rsp_ready = 1'b0;
      issue(OP_READ, '0, '0, 1, 1'b1, 32'h0000_0055, 2);
      get_rsp("bp_read");
      bus.cmd_valid = 1'b1;
      bus.cmd_op = OP_NOP;
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         checks++;
         if ({bus.rsp_valid, bus.cmd_ready, bus.rsp_data}
             !== {1'b1, 1'b0, 32'h0000_0055}) begin
            errors++;
            $display("FAIL bp_hold%0d: valid=%b ready=%b data=%h required 1 0 00000055",
                     k, bus.rsp_valid, bus.cmd_ready, bus.rsp_data);
         end
      end
      sb.push_back('{any: 1'b1, data: '0, lat: 1});
      bus.rsp_ready = 1'b1;
      @(posedge CLK);
      @(posedge CLK);
      #1;
      bus.cmd_valid = 1'b0;
      checks++;
      if (acc_cyc != hs_cyc + 1) begin
         errors++;
         $display("FAIL bp_accept: accept cycle %0d required %0d",
                  acc_cyc, hs_cyc + 1);
      end
      get_rsp("bp_nop");
   endtask

   task automatic test_reset_mid();
      bit seen;
      issue(OP_SEARCH, 32'h0000_0055, 32'hFFFF_FFFF,
            0, 1'b0, '0, 0);
      #2;
      checks++;
      if (perform_search !== 1'b1) begin
         errors++;
         $display("FAIL mid_pre: perform_search=%b required 1",
                  perform_search);
      end
      RST = 1'b1;
      #1;
      checks++;
      if ({perform_search, busy, bus.rsp_valid} !== 3'b0) begin
         errors++;
         $display("FAIL mid_drop: ps/busy/rsp=%b required 000",
                  {perform_search, busy, bus.rsp_valid});
      end
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      checks++;
      if (bus.cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_ready: cmd_ready=%b required 1",
                  bus.cmd_ready);
      end
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge CLK);
         if (bus.rsp_valid) seen = 1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL mid_norsp: rsp_valid seen=1 required 0");
      end
      issue(OP_NOP, '0, '0, 1, 1'b1, '0, 1);
      get_rsp("mid_nop");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_nop();
      test_search();
      test_write();
      test_search_write_nomatch();
      test_search_write_match();
      test_read_next();
      test_backpressure();
      test_reset_mid();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d entries left required 0",
                  sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
